// File: rtl/except_pkg.sv
// Shared exception codes, default vector and the candidate priority encoder
// used by the precise-exception unit.
package except_pkg;

   typedef logic [31:0] exc_code_t;

   localparam exc_code_t EXC_NONE = 32'h0000_0000;
   localparam exc_code_t EXC_INT  = 32'h0000_0001;
   localparam exc_code_t EXC_ADEL = 32'h0000_0004;
   localparam exc_code_t EXC_ADES = 32'h0000_0005;
   localparam exc_code_t EXC_SYS  = 32'h0000_0008;
   localparam exc_code_t EXC_BP   = 32'h0000_0009;
   localparam exc_code_t EXC_RI   = 32'h0000_000a;
   localparam exc_code_t EXC_OV   = 32'h0000_000c;
   localparam exc_code_t EXC_TR   = 32'h0000_000d;
   localparam exc_code_t EXC_ERET = 32'h0000_000e;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   // Fixed priority: interrupts first, eret last; EXC_NONE when nothing is raised.
   function automatic exc_code_t exc_select(
      input logic irq,
      input logic adel,
      input logic pc_err,
      input logic ri,
      input logic syscall,
      input logic brk,
      input logic ades,
      input logic overflow,
      input logic trap,
      input logic eret
   );
      exc_code_t code;
      if (irq)                  code = EXC_INT;
      else if (adel || pc_err)  code = EXC_ADEL;
      else if (ri)              code = EXC_RI;
      else if (syscall)         code = EXC_SYS;
      else if (brk)             code = EXC_BP;
      else if (ades)            code = EXC_ADES;
      else if (overflow)        code = EXC_OV;
      else if (trap)            code = EXC_TR;
      else if (eret)            code = EXC_ERET;
      else                      code = EXC_NONE;
      return code;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second clock, Compare match
// raises a sticky timer interrupt cleared only by a Compare write.
module cp0_timer
   import except_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_int
);

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        phase_q, phase_d;
   logic        timer_int_q, timer_int_d;

   always_comb begin
      phase_d     = ~phase_q;
      count_d     = count_q;
      compare_d   = compare_q;
      timer_int_d = timer_int_q;

      // A software write to Count restarts the half-rate phase.
      if (count_we) begin
         count_d = cp0_wdata;
         phase_d = 1'b0;
      end else if (phase_q) begin
         count_d = count_q + 32'd1;
      end

      if (compare_we) begin
         compare_d   = cp0_wdata;
         timer_int_d = 1'b0;
      end else if (count_q == compare_q) begin
         timer_int_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= '0;
         compare_q   <= '0;
         phase_q     <= 1'b0;
         timer_int_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         compare_q   <= compare_d;
         phase_q     <= phase_d;
         timer_int_q <= timer_int_d;
      end
   end

   assign count     = count_q;
   assign compare   = compare_q;
   assign timer_int = timer_int_q;

endmodule

// File: rtl/except_unit_v2.sv
// M-stage precise-exception unit: interrupt synchronisation, candidate
// prioritisation, single commit per exception with a registered flush window.
module except_unit_v2
   import except_pkg::*;
#(
   parameter int          N_EXT_INT    = 6,
   parameter int          SYNC_STAGES  = 2,
   parameter int          FLUSH_CYCLES = 1,
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
   parameter bit          TIMER_EN     = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_EXT_INT-1:0] ext_int,
   input  logic                 ri,
   input  logic                 brk,
   input  logic                 syscall,
   input  logic                 overflow,
   input  logic                 trap,
   input  logic                 eretM,
   input  logic                 adel,
   input  logic                 ades,
   input  logic                 pc_err,
   input  logic                 validM,
   input  logic                 stallM,
   input  logic                 in_delayslotM,
   input  logic [31:0]          pcM,
   input  logic [31:0]          aluoutM,
   input  logic [31:0]          cp0_status,
   input  logic [31:0]          cp0_cause,
   input  logic [31:0]          cp0_epc,
   input  logic                 compare_we,
   input  logic                 count_we,
   input  logic [31:0]          cp0_wdata,
   output logic [31:0]          except_type,
   output logic                 flush,
   output logic [31:0]          pc_exception,
   output logic                 cp0_exc_we,
   output logic [31:0]          epc_out,
   output logic                 bd_out,
   output logic [31:0]          badvaddr_out,
   output logic [5:0]           ip_hw,
   output logic [31:0]          count,
   output logic [31:0]          compare,
   output logic                 timer_int
);

   // ---------------- interrupt synchronisers ----------------
   logic [N_EXT_INT-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [5:0]                            ip_sync;

   always_comb begin
      for (int i = 0; i < N_EXT_INT; i++) begin
         sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], ext_int[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_ip
         if (gi < N_EXT_INT) begin : g_line
            assign ip_sync[gi] = sync_q[gi][SYNC_STAGES-1];
         end else begin : g_tie
            assign ip_sync[gi] = 1'b0;
         end
      end
   endgenerate

   // ---------------- timer ----------------
   generate
      if (TIMER_EN) begin : g_timer
         cp0_timer u_timer (
            .clk        (clk),
            .rst        (rst),
            .count_we   (count_we),
            .compare_we (compare_we),
            .cp0_wdata  (cp0_wdata),
            .count      (count),
            .compare    (compare),
            .timer_int  (timer_int)
         );
      end else begin : g_no_timer
         assign count     = '0;
         assign compare   = '0;
         assign timer_int = 1'b0;
      end
   endgenerate

   assign ip_hw = {ip_sync[5] | timer_int, ip_sync[4:0]};

   // ---------------- candidate selection ----------------
   logic      irq;
   logic      busy;
   logic      commit;
   exc_code_t cand;

   // Software IP[1:0] comes from Cause; hardware IP[7:2] from the synchronisers.
   assign irq = cp0_status[0] & ~cp0_status[1]
              & (|(cp0_status[15:8] & {ip_hw, cp0_cause[9:8]}));

   assign cand = exc_select(irq, adel, pc_err, ri, syscall, brk, ades,
                            overflow, trap, eretM);

   assign commit = (cand != EXC_NONE) & validM & ~stallM & ~busy;

   // ---------------- commit registers ----------------
   logic        flush_q, flush_d;
   logic [1:0]  flush_cnt_q, flush_cnt_d;
   logic        exc_we_q, exc_we_d;
   exc_code_t   type_q, type_d;
   logic [31:0] pc_exc_q, pc_exc_d;
   logic [31:0] epc_q, epc_d;
   logic        bd_q, bd_d;
   logic [31:0] badvaddr_q, badvaddr_d;

   // Instructions behind a committed exception are being flushed, so the
   // flush window doubles as the busy interval.
   assign busy = flush_q;

   always_comb begin
      flush_d     = flush_q;
      flush_cnt_d = flush_cnt_q;
      exc_we_d    = 1'b0;
      type_d      = type_q;
      pc_exc_d    = pc_exc_q;
      epc_d       = epc_q;
      bd_d        = bd_q;
      badvaddr_d  = badvaddr_q;

      if (commit) begin
         flush_d     = 1'b1;
         flush_cnt_d = 2'(FLUSH_CYCLES - 1);
         exc_we_d    = (cand != EXC_ERET);
         type_d      = cand;
         pc_exc_d    = (cand == EXC_ERET) ? cp0_epc : EXC_VECTOR;
         epc_d       = in_delayslotM ? (pcM - 32'd4) : pcM;
         bd_d        = in_delayslotM;
         badvaddr_d  = pc_err ? pcM : aluoutM;
      end else if (flush_q) begin
         if (flush_cnt_q == 2'd0) begin
            flush_d = 1'b0;
         end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_q     <= 1'b0;
         flush_cnt_q <= '0;
         exc_we_q    <= 1'b0;
         type_q      <= EXC_NONE;
         pc_exc_q    <= '0;
         epc_q       <= '0;
         bd_q        <= 1'b0;
         badvaddr_q  <= '0;
      end else begin
         flush_q     <= flush_d;
         flush_cnt_q <= flush_cnt_d;
         exc_we_q    <= exc_we_d;
         type_q      <= type_d;
         pc_exc_q    <= pc_exc_d;
         epc_q       <= epc_d;
         bd_q        <= bd_d;
         badvaddr_q  <= badvaddr_d;
      end
   end

   assign except_type  = type_q;
   assign flush        = flush_q;
   assign pc_exception = pc_exc_q;
   assign cp0_exc_we   = exc_we_q;
   assign epc_out      = epc_q;
   assign bd_out       = bd_q;
   assign badvaddr_out = badvaddr_q;

   wire unused_cp0 = &{1'b0, cp0_status[31:16], cp0_status[7:2],
                       cp0_cause[31:10], cp0_cause[7:0]};

endmodule

// File: tb/tb_except_unit_v2.sv
// Directed plus randomized checks of except_unit_v2 against a behavioural
// reference (timer as base + elapsed/2, priority table, fixed flush window).
module tb_except_unit_v2;

   localparam int          NX  = 6;
   localparam int          SS  = 2;
   localparam int          FC  = 3;
   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic        clk;
   logic        rst;
   logic [NX-1:0] ext_int;
   logic        ri, brk, syscall, overflow, trap, eretM;
   logic        adel, ades, pc_err;
   logic        validM, stallM, in_delayslotM;
   logic [31:0] pcM, aluoutM;
   logic [31:0] cp0_status, cp0_cause, cp0_epc;
   logic        compare_we, count_we;
   logic [31:0] cp0_wdata;
   logic [31:0] except_type;
   logic        flush;
   logic [31:0] pc_exception;
   logic        cp0_exc_we;
   logic [31:0] epc_out;
   logic        bd_out;
   logic [31:0] badvaddr_out;
   logic [5:0]  ip_hw;
   logic [31:0] count, compare;
   logic        timer_int;

   except_unit_v2 #(
      .N_EXT_INT    (NX),
      .SYNC_STAGES  (SS),
      .FLUSH_CYCLES (FC),
      .EXC_VECTOR   (VEC),
      .TIMER_EN     (1'b1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ext_int       (ext_int),
      .ri            (ri),
      .brk           (brk),
      .syscall       (syscall),
      .overflow      (overflow),
      .trap          (trap),
      .eretM         (eretM),
      .adel          (adel),
      .ades          (ades),
      .pc_err        (pc_err),
      .validM        (validM),
      .stallM        (stallM),
      .in_delayslotM (in_delayslotM),
      .pcM           (pcM),
      .aluoutM       (aluoutM),
      .cp0_status    (cp0_status),
      .cp0_cause     (cp0_cause),
      .cp0_epc       (cp0_epc),
      .compare_we    (compare_we),
      .count_we      (count_we),
      .cp0_wdata     (cp0_wdata),
      .except_type   (except_type),
      .flush         (flush),
      .pc_exception  (pc_exception),
      .cp0_exc_we    (cp0_exc_we),
      .epc_out       (epc_out),
      .bd_out        (bd_out),
      .badvaddr_out  (badvaddr_out),
      .ip_hw         (ip_hw),
      .count         (count),
      .compare       (compare),
      .timer_int     (timer_int)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference timer/interrupt state
   logic [31:0] m_base;
   int unsigned m_since;
   logic [31:0] m_cmp;
   logic        m_ti;
   logic [5:0]  m_sync [SS];

   function automatic logic [31:0] m_count();
      return m_base + 32'(m_since / 2);
   endfunction

   function automatic logic [31:0] exp_code(input logic i_irq, i_adel, i_pcerr,
      i_ri, i_sys, i_brk, i_ades, i_ov, i_tr, i_eret);
      logic        flags [9];
      logic [31:0] codes [9];
      flags = '{i_irq, i_adel | i_pcerr, i_ri, i_sys, i_brk, i_ades, i_ov, i_tr, i_eret};
      codes = '{32'h1, 32'h4, 32'ha, 32'h8, 32'h9, 32'h5, 32'hc, 32'hd, 32'he};
      for (int k = 0; k < 9; k++) begin
         if (flags[k]) return codes[k];
      end
      return 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [31:0] cnt_before;
      cnt_before = m_count();
      @(posedge clk);
      if (rst) begin
         m_base = '0; m_since = 0; m_cmp = '0; m_ti = 1'b0;
         for (int i = 0; i < SS; i++) m_sync[i] = '0;
      end else begin
         if (compare_we)                m_ti = 1'b0;
         else if (cnt_before == m_cmp)  m_ti = 1'b1;
         if (compare_we) m_cmp = cp0_wdata;
         if (count_we) begin
            m_base = cp0_wdata; m_since = 0;
         end else begin
            m_since++;
         end
         for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
         m_sync[0] = 6'(ext_int);
      end
      #2;
      chk("count",     count,             m_count());
      chk("compare",   compare,           m_cmp);
      chk("timer_int", {31'b0, timer_int}, {31'b0, m_ti});
      chk("ip_hw",     {26'b0, ip_hw},
          {26'b0, m_sync[SS-1][5] | m_ti, m_sync[SS-1][4:0]});
   endtask

   task automatic clear_flags();
      ri = 0; brk = 0; syscall = 0; overflow = 0; trap = 0; eretM = 0;
      adel = 0; ades = 0; pc_err = 0; validM = 0; stallM = 0; in_delayslotM = 0;
      compare_we = 0; count_we = 0;
   endtask

   task automatic chk_commit(input string tag, input logic [31:0] code,
      input logic [31:0] pcx, input logic [31:0] epc, input logic bd,
      input logic [31:0] bva, input logic we);
      chk({tag, ".flush"},   {31'b0, flush},      32'h1);
      chk({tag, ".type"},    except_type,          code);
      chk({tag, ".pcexc"},   pc_exception,         pcx);
      chk({tag, ".epc"},     epc_out,              epc);
      chk({tag, ".bd"},      {31'b0, bd_out},      {31'b0, bd});
      chk({tag, ".badva"},   badvaddr_out,         bva);
      chk({tag, ".exc_we"},  {31'b0, cp0_exc_we},  {31'b0, we});
   endtask

   logic [31:0] last_type, last_epc, e_code;
   logic        exp_commit;

   initial begin
      rst = 1; ext_int = '0;
      clear_flags();
      pcM = '0; aluoutM = '0; cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
      cp0_wdata = '0;
      m_base = '0; m_since = 0; m_cmp = '0; m_ti = 1'b0;
      for (int i = 0; i < SS; i++) m_sync[i] = '0;

      // Reset state
      repeat (3) tick();
      chk("rst.type",   except_type,             32'h0);
      chk("rst.flush",  {31'b0, flush},          32'h0);
      chk("rst.pcexc",  pc_exception,            32'h0);
      chk("rst.exc_we", {31'b0, cp0_exc_we},     32'h0);
      chk("rst.epc",    epc_out,                 32'h0);
      chk("rst.bd",     {31'b0, bd_out},         32'h0);
      chk("rst.badva",  badvaddr_out,            32'h0);

      // Count runs at half rate from reset
      rst = 0;
      repeat (2) tick();
      chk("count.2cyc", count, 32'd1);
      repeat (2) tick();
      chk("count.4cyc", count, 32'd2);

      // Move Compare away so the timer stays quiet
      compare_we = 1; cp0_wdata = 32'hFFFF_0000; tick(); compare_we = 0;

      // Syscall commit and flush window length
      validM = 1; syscall = 1; pcM = 32'hBFC0_1000; aluoutM = 32'h0000_0040;
      tick();
      chk_commit("sys", 32'h8, VEC, 32'hBFC0_1000, 1'b0, 32'h0000_0040, 1'b1);
      clear_flags();
      tick();
      chk("sys.flush2", {31'b0, flush},      32'h1);
      chk("sys.we2",    {31'b0, cp0_exc_we}, 32'h0);
      tick();
      chk("sys.flush3", {31'b0, flush},      32'h1);
      tick();
      chk("sys.flush4", {31'b0, flush},      32'h0);
      chk("sys.hold",   except_type,         32'h8);

      // AdEL beats RI, delay slot EPC
      validM = 1; adel = 1; ri = 1; in_delayslotM = 1;
      pcM = 32'h8000_0104; aluoutM = 32'h0000_0003;
      tick();
      chk_commit("adel", 32'h4, VEC, 32'h8000_0100, 1'b1, 32'h0000_0003, 1'b1);
      clear_flags();
      repeat (FC) tick();
      chk("adel.drain", {31'b0, flush}, 32'h0);

      // Reset during the flush window
      validM = 1; syscall = 1; pcM = 32'h8000_0200;
      tick();
      chk("rstmid.flush0", {31'b0, flush}, 32'h1);
      clear_flags(); rst = 1;
      tick();
      chk("rstmid.flush", {31'b0, flush}, 32'h0);
      chk("rstmid.type",  except_type,    32'h0);
      rst = 0;
      compare_we = 1; cp0_wdata = 32'hFFFF_0000; tick(); compare_we = 0;

      // External interrupt through the synchroniser
      cp0_status = 32'h0000_8001; ext_int = 6'b100000; aluoutM = 32'h1234_5678;
      pcM = 32'h8000_2000;
      tick();
      chk("irq.sync1", {31'b0, flush}, 32'h0);
      tick();
      chk("irq.sync2", {31'b0, flush}, 32'h0);
      tick();
      chk("irq.bubble", {31'b0, flush}, 32'h0);
      validM = 1; stallM = 1;
      tick();
      chk("irq.stall", {31'b0, flush}, 32'h0);
      stallM = 0; syscall = 1;
      tick();
      chk_commit("irq", 32'h1, VEC, 32'h8000_2000, 1'b0, 32'h1234_5678, 1'b1);
      clear_flags(); ext_int = '0; cp0_status = '0;
      repeat (FC) tick();
      chk("irq.drain", {31'b0, flush}, 32'h0);

      // eret held by a stall, then a trap during the flush window
      validM = 1; eretM = 1; stallM = 1; cp0_epc = 32'hBFC0_2000; pcM = 32'h8000_3000;
      aluoutM = 32'h0;
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("eret.stall", {31'b0, flush}, 32'h0);
      end
      stallM = 0;
      tick();
      chk_commit("eret", 32'he, 32'hBFC0_2000, 32'h8000_3000, 1'b0, 32'h0, 1'b0);
      eretM = 0; trap = 1;
      tick();
      chk("eret.f2", {31'b0, flush}, 32'h1);
      tick();
      chk("eret.f3", {31'b0, flush}, 32'h1);
      tick();
      chk("eret.f4",   {31'b0, flush}, 32'h0);
      chk("eret.hold", except_type,    32'he);
      clear_flags();
      tick();

      // Timer: match sets timer_int; Compare write on a second match clears it
      count_we = 1; cp0_wdata = 32'd5; tick(); count_we = 0;
      compare_we = 1; cp0_wdata = 32'd10; tick(); compare_we = 0;
      repeat (10) tick();
      chk("timer.set", {31'b0, timer_int}, 32'h1);
      compare_we = 1; cp0_wdata = 32'd10; tick(); compare_we = 0;
      chk("timer.clr", {31'b0, timer_int}, 32'h0);
      tick();
      chk("timer.stay", {31'b0, timer_int}, 32'h0);

      // Count wraps
      count_we = 1; cp0_wdata = 32'hFFFF_FFFF; tick(); count_we = 0;
      repeat (2) tick();
      chk("count.wrap", count, 32'h0);
      compare_we = 1; cp0_wdata = 32'hFFFF_0000; tick(); compare_we = 0;

      // Randomized transactions against the reference
      last_type = 32'he; last_epc = 32'h8000_3000;
      for (int t = 0; t < 40; t++) begin
         ri       = ($urandom_range(0, 5) == 0);
         brk      = ($urandom_range(0, 5) == 0);
         syscall  = ($urandom_range(0, 5) == 0);
         overflow = ($urandom_range(0, 5) == 0);
         trap     = ($urandom_range(0, 5) == 0);
         eretM    = ($urandom_range(0, 5) == 0);
         adel     = ($urandom_range(0, 7) == 0);
         ades     = ($urandom_range(0, 5) == 0);
         pc_err   = ($urandom_range(0, 7) == 0);
         validM   = ($urandom_range(0, 5) != 0);
         stallM   = ($urandom_range(0, 4) == 0);
         in_delayslotM = 1'($urandom_range(0, 1));
         pcM = $urandom; aluoutM = $urandom; cp0_epc = $urandom;
         e_code = exp_code(1'b0, adel, pc_err, ri, syscall, brk, ades, overflow, trap, eretM);
         exp_commit = (e_code != 0) && validM && !stallM;
         if (exp_commit) begin
            last_type = e_code;
            last_epc  = in_delayslotM ? pcM - 32'd4 : pcM;
            tick();
            chk_commit("rand", e_code, (e_code == 32'he) ? cp0_epc : VEC, last_epc,
                       in_delayslotM, pc_err ? pcM : aluoutM, e_code != 32'he);
         end else begin
            tick();
            chk("rand.noflush", {31'b0, flush}, 32'h0);
            chk("rand.hold",    except_type,    last_type);
            chk("rand.holdepc", epc_out,        last_epc);
         end
         clear_flags();
         repeat (FC) tick();
         chk("rand.drain", {31'b0, flush}, 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/except_unit_v2.md
Name: except_unit_v2

Overview:
Second-generation precise-exception unit for the MIPS-style 5-stage core, evaluated at the M stage. It prioritises interrupts and synchronous exceptions, then commits each exception once with a registered, multi-cycle flush window. It synchronises a parametrised number of external interrupt lines, owns the Count/Compare timer, and produces EPC/BD/BadVAddr write data for CP0. It sits between the M-stage pipeline register and cp0_reg, and drives the hazard unit's flush and the fetch-stage PC mux.

Parameters:
N_EXT_INT, 6, number of external interrupt lines (1..6); line i maps to Cause.IP[2+i]
SYNC_STAGES, 2, flop stages on each ext_int line (>=2)
FLUSH_CYCLES, 1, cycles flush stays high after a commit (1..4)
EXC_VECTOR, 32'hBFC0_0380, general exception entry address
TIMER_EN, 1, 0 removes the timer; timer_int is tied to 0

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
ext_int  in  N_EXT_INT  asynchronous hardware interrupt levels
ri, brk, syscall, overflow, trap, eretM  in  1 each  M-stage exception flags
adel, ades, pc_err  in  1 each  load/fetch address error, store address error, PC misalignment
validM  in  1  M stage holds a real instruction
stallM  in  1  M stage stalled this cycle
in_delayslotM  in  1  M instruction sits in a branch delay slot
pcM, aluoutM  in  32 each  M-stage PC and effective address
cp0_status, cp0_cause, cp0_epc  in  32 each  current CP0 values
compare_we, count_we  in  1 each  MTC0 write strobes
cp0_wdata  in  32  MTC0 data
except_type  out  32  latched code: 1 int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, a RI, c Ov, d Tr, e eret
flush  out  1  pipeline flush
pc_exception  out  32  redirect target, valid while flush=1
cp0_exc_we  out  1  one-cycle strobe to update EPC/BD/ExcCode/BadVAddr
epc_out  out  32  EPC write value
bd_out  out  1  Cause.BD write value
badvaddr_out  out  32  BadVAddr write value
ip_hw  out  6  synchronised IP[7:2], including the timer
count, compare  out  32 each  timer registers
timer_int  out  1  Cause.TI

Behaviour:
- Reset: every output and internal register is 0, including the sync chains, count, compare, timer_int, busy and the phase bit.
- Synchronisation: each ext_int bit passes through SYNC_STAGES flops. ip_hw[i] = sync[i] for i < N_EXT_INT, otherwise 0. ip_hw[5] is additionally ORed with timer_int.
- Timer:
  - count increments on every second clk using a phase toggle; it wraps from FFFF_FFFF to 0.
  - timer_int sets on the cycle after count==compare. It stays set until compare_we.
  - count_we loads cp0_wdata and clears the phase. A write beats the increment in the same cycle.
  - compare_we loads compare and clears timer_int. The clear beats a simultaneous match.
- Interrupt pending: irq = Status.IE & ~Status.EXL & |((Status.IM[15:8] & {ip_hw, Cause.IP[1:0]})).
- Candidate priority, first match wins: irq, adel|pc_err, ri, syscall, brk, ades, overflow, trap, eretM.
- Commit (cycle T): requires a candidate, validM=1, stallM=0 and busy=0.
  - Stalled: no commit, and the inputs must hold.
  - Bubbles (validM=0) never take interrupts.
  - During busy, candidates are ignored because those instructions are being flushed.
- Commit outputs (cycle T+1):
  - flush=1 for exactly FLUSH_CYCLES cycles; busy covers the same window.
  - except_type, epc_out, bd_out, badvaddr_out and pc_exception are latched at T and held until the next commit.
  - pc_exception = cp0_epc for eret, otherwise EXC_VECTOR.
  - epc_out = in_delayslotM ? pcM-4 : pcM (32-bit wrap). bd_out = in_delayslotM.
  - badvaddr_out = pc_err ? pcM : aluoutM.
  - cp0_exc_we pulses for one cycle at T+1 for every commit except eret.
- Simultaneous irq and synchronous exception: except_type=1. EPC uses this instruction's PC; the faulting instruction re-executes later.
- Reset asserted mid-flush drops flush and busy on the next edge.

Decomposition:
- except_pkg holds the EXC_* 32-bit code localparams, the default EXC_VECTOR, and an exc_code_t typedef.
- Sub-module cp0_timer holds count, compare, phase and timer_int. It is instantiated when TIMER_EN=1.

Test Plan:
- Reset, then release → all outputs 0. count reads 1 after 2 cycles and 2 after 4.
- syscall with validM=1 and pcM=BFC0_1000, not in a delay slot → at T+1: except_type=8, flush=1, pc_exception=BFC0_0380, epc_out=BFC0_1000, bd_out=0, cp0_exc_we=1.
- adel and ri together, in_delayslotM=1, pcM=8000_0104, aluoutM=0000_0003 → except_type=4, epc_out=8000_0100, bd_out=1, badvaddr_out=0000_0003.
- Set Status IE=1, IM7=1, EXL=0, then ext_int[5]=1 → no commit before SYNC_STAGES cycles. Then except_type=1 on the first validM, non-stalled cycle.
- compare=10 → timer_int=1 after count==10. A compare_we in the same cycle as a second match leaves timer_int=0.
- eretM with cp0_epc=BFC0_2000, stallM=1 for 3 cycles → no flush until the stall drops. Then pc_exception=BFC0_2000 and cp0_exc_we=0. With FLUSH_CYCLES=3, flush is high 3 cycles and a trap raised meanwhile is ignored.
